// File: rtl/dso_spi_pkg.sv
// Shared types for the DSO SPI slave-select controller: targets, FSM states, requesters.
package dso_spi_pkg;

  localparam int unsigned CMD_W_DEF = 16;
  localparam int unsigned NUM_SS    = 5;

  typedef enum logic [2:0] {
    TGT_CH1  = 3'd0,
    TGT_CH2  = 3'd1,
    TGT_CH3  = 3'd2,
    TGT_TRIG = 3'd3,
    TGT_EEP  = 3'd4
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_XFER,
    ST_RESP
  } state_e;

  typedef enum logic {
    REQ_CFG,
    REQ_EEP
  } req_e;

  function automatic logic tgt_legal(input logic [2:0] tgt);
    return (tgt <= 3'(TGT_EEP));
  endfunction

endpackage

// File: rtl/spi_ss_timer.sv
// Loadable down-counter used both for the inter-transaction SS-high gap and the done timeout.
module spi_ss_timer #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/spi_ss_ctrl.sv
// Arbitrates the single-SS SPI master between the cfg and eep requesters and
// decodes the master's slave select onto the five per-device selects.
module spi_ss_ctrl
  import dso_spi_pkg::*;
#(
  parameter int unsigned CMD_W       = CMD_W_DEF,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [2:0]       cfg_tgt,
  input  logic [CMD_W-1:0] cfg_cmd,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic             eep_req,
  input  logic [2:0]       eep_tgt,
  input  logic [CMD_W-1:0] eep_cmd,
  output logic             eep_done,
  output logic             eep_err,
  output logic [CMD_W-1:0] rdata,
  output logic             mstr_wrt,
  output logic [CMD_W-1:0] mstr_cmd,
  input  logic             mstr_SS_n,
  input  logic             mstr_done,
  input  logic [CMD_W-1:0] mstr_data,
  output logic             ch1_ss_n,
  output logic             ch2_ss_n,
  output logic             ch3_ss_n,
  output logic             trig_ss_n,
  output logic             EEP_ss_n
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_e            state_q, state_d;
  req_e              owner_q, owner_d;
  req_e              last_q, last_d;
  logic [2:0]        tgt_q, tgt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [CMD_W-1:0]  rdata_q, rdata_d;
  logic              wrt_q, wrt_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic              cfg_done_q, cfg_done_d, cfg_err_q, cfg_err_d;
  logic              eep_done_q, eep_done_d, eep_err_q, eep_err_d;

  req_e              pick;
  logic [2:0]        pick_tgt;
  logic [CMD_W-1:0]  pick_cmd;
  logic              fin, fin_err, active;
  logic              tmr_load, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;

  spi_ss_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    tgt_d    = tgt_q;
    cmd_d    = cmd_q;
    rdata_d  = rdata_q;
    fin      = 1'b0;
    fin_err  = 1'b0;

    // Round-robin: on a tie the requester not served last time wins.
    pick     = (cfg_req && (!eep_req || last_q == REQ_EEP)) ? REQ_CFG : REQ_EEP;
    pick_tgt = (pick == REQ_CFG) ? cfg_tgt : eep_tgt;
    pick_cmd = (pick == REQ_CFG) ? cfg_cmd : eep_cmd;

    // One timer serves both uses: timeout armed at LAUNCH, gap armed at RESP.
    tmr_load = (state_q == ST_LAUNCH) || (state_q == ST_RESP);
    tmr_val  = (state_q == ST_LAUNCH) ? TMR_W'(TIMEOUT_CYC) : TMR_W'(GAP_CYC);

    unique case (state_q)
      ST_IDLE: begin
        if (tmr_expired && (cfg_req || eep_req)) begin
          owner_d = pick;
          last_d  = pick;
          tgt_d   = pick_tgt;
          if (tgt_legal(pick_tgt)) begin
            cmd_d   = pick_cmd;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_RESP;
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
      end
      ST_LAUNCH: state_d = ST_XFER;
      ST_XFER: begin
        if (mstr_done) begin
          rdata_d = mstr_data;
          state_d = ST_RESP;
          fin     = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_RESP;
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Done/err are registered on entry to RESP so they appear for exactly the RESP cycle.
    cfg_done_d = fin && (owner_d == REQ_CFG);
    cfg_err_d  = fin_err && (owner_d == REQ_CFG);
    eep_done_d = fin && (owner_d == REQ_EEP);
    eep_err_d  = fin_err && (owner_d == REQ_EEP);
    wrt_d      = (state_d == ST_LAUNCH);

    active = (state_d == ST_LAUNCH) || (state_d == ST_XFER);
    ss_d   = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (active && tgt_d == 3'(i)) begin
        ss_d[i] = mstr_SS_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= REQ_CFG;
      last_q     <= REQ_EEP;
      tgt_q      <= '0;
      cmd_q      <= '0;
      rdata_q    <= '0;
      wrt_q      <= 1'b0;
      ss_q       <= '1;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      eep_done_q <= 1'b0;
      eep_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      tgt_q      <= tgt_d;
      cmd_q      <= cmd_d;
      rdata_q    <= rdata_d;
      wrt_q      <= wrt_d;
      ss_q       <= ss_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      eep_done_q <= eep_done_d;
      eep_err_q  <= eep_err_d;
    end
  end

  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign eep_done  = eep_done_q;
  assign eep_err   = eep_err_q;
  assign rdata     = rdata_q;
  assign mstr_wrt  = wrt_q;
  assign mstr_cmd  = cmd_q;
  assign ch1_ss_n  = ss_q[0];
  assign ch2_ss_n  = ss_q[1];
  assign ch3_ss_n  = ss_q[2];
  assign trig_ss_n = ss_q[3];
  assign EEP_ss_n  = ss_q[4];

endmodule

// File: tb/tb_spi_ss_ctrl.sv
// Bench for spi_ss_ctrl: acts as SPI_mstr and both requesters, predicting grants,
// selects and completions from a transaction-level model.
module tb_spi_ss_ctrl;

  localparam int CW  = 16;
  localparam int GAP = 4;
  localparam int TMO = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_req = 1'b0, eep_req = 1'b0;
  logic [2:0]    cfg_tgt = '0, eep_tgt = '0;
  logic [CW-1:0] cfg_cmd = '0, eep_cmd = '0;
  logic          cfg_done, cfg_err, eep_done, eep_err;
  logic [CW-1:0] rdata, mstr_cmd;
  logic          mstr_wrt;
  logic          mstr_SS_n = 1'b1, mstr_done = 1'b0;
  logic [CW-1:0] mstr_data = '0;
  logic          ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;

  spi_ss_ctrl #(
    .CMD_W       (CW),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_req   (cfg_req),
    .cfg_tgt   (cfg_tgt),
    .cfg_cmd   (cfg_cmd),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .eep_req   (eep_req),
    .eep_tgt   (eep_tgt),
    .eep_cmd   (eep_cmd),
    .eep_done  (eep_done),
    .eep_err   (eep_err),
    .rdata     (rdata),
    .mstr_wrt  (mstr_wrt),
    .mstr_cmd  (mstr_cmd),
    .mstr_SS_n (mstr_SS_n),
    .mstr_done (mstr_done),
    .mstr_data (mstr_data),
    .ch1_ss_n  (ch1_ss_n),
    .ch2_ss_n  (ch2_ss_n),
    .ch3_ss_n  (ch3_ss_n),
    .trig_ss_n (trig_ss_n),
    .EEP_ss_n  (EEP_ss_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: who was served last (0 cfg, 1 eep) and the last captured read data.
  int            exp_last = 1;
  logic [CW-1:0] exp_rdata = '0;

  bit            obs_wrt, obs_done_seen, obs_wrt_one, obs_cmd_stable, obs_ss_ok, obs_done_one;
  int            obs_lat, obs_wrt_cyc, obs_done_cyc;
  logic [CW-1:0] obs_cmd, obs_rd;
  logic          obs_cd, obs_ce, obs_ed, obs_ee;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ss_vec();
    return {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};
  endfunction

  function automatic logic [4:0] exp_ss(input logic [2:0] tgt, input logic v);
    logic [4:0] r;
    r = 5'h1F;
    if (tgt < 3'd5) r[tgt] = v;
    return r;
  endfunction

  function automatic int predict(input logic c, input logic e);
    if (c && e) return (exp_last == 1) ? 0 : 1;
    return c ? 0 : 1;
  endfunction

  task automatic capture_done();
    obs_cd = cfg_done; obs_ce = cfg_err; obs_ed = eep_done; obs_ee = eep_err;
    obs_rd = rdata; obs_done_cyc = cyc;
    obs_done_seen = cfg_done | eep_done;
    if (ss_vec() !== 5'h1F) obs_ss_ok = 1'b0;
  endtask

  // Plays SPI_mstr for one transaction; records observations for the calling test.
  task automatic run_txn(input logic [2:0] tgt, input logic [CW-1:0] data, input int ss_len);
    obs_wrt = 0; obs_done_seen = 0; obs_wrt_one = 1; obs_cmd_stable = 1; obs_ss_ok = 1;
    obs_done_one = 1; obs_lat = 0; obs_wrt_cyc = 0; obs_cmd = '0;
    obs_cd = 0; obs_ce = 0; obs_ed = 0; obs_ee = 0; obs_rd = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mstr_wrt) begin
        obs_wrt = 1; obs_lat = i; obs_cmd = mstr_cmd; obs_wrt_cyc = cyc;
        break;
      end
      if (cfg_done || eep_done) begin
        obs_lat = i;
        capture_done();
        break;
      end
    end
    if (obs_wrt) begin
      for (int k = 0; k < ss_len; k++) begin
        mstr_SS_n = 1'b0;
        tick();
        if (mstr_wrt) obs_wrt_one = 0;
        if (mstr_cmd !== obs_cmd) obs_cmd_stable = 0;
        if (ss_vec() !== exp_ss(tgt, 1'b0)) obs_ss_ok = 0;
      end
      mstr_SS_n = 1'b1;
      tick();
      if (ss_vec() !== exp_ss(tgt, 1'b1)) obs_ss_ok = 0;
      mstr_data = data; mstr_done = 1'b1;
      tick();
      mstr_done = 1'b0; mstr_data = 16'($urandom);
      capture_done();
    end
    tick();
    if (cfg_done || eep_done) obs_done_one = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ss_vec() !== 5'h1F) begin errors++; $display("FAIL rst_ss: got %b expected 11111", ss_vec()); end
    checks++; if (mstr_wrt !== 1'b0) begin errors++; $display("FAIL rst_wrt: got %b expected 0", mstr_wrt); end
    checks++; if (mstr_cmd !== 16'h0000) begin errors++; $display("FAIL rst_cmd: got %h expected 0000", mstr_cmd); end
    checks++; if ({cfg_done, cfg_err, eep_done, eep_err} !== 4'b0000) begin
      errors++; $display("FAIL rst_done: got %b expected 0000", {cfg_done, cfg_err, eep_done, eep_err}); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    exp_last = 1; exp_rdata = '0;
  endtask

  task automatic test_single();
    cfg_tgt = 3'd2; cfg_cmd = 16'hA5C3; cfg_req = 1'b1;
    run_txn(3'd2, 16'h00FF, 3 + int'($urandom_range(0, 3)));
    cfg_req = 1'b0;
    checks++; if (obs_wrt !== 1'b1) begin errors++; $display("FAIL t1_wrt: got %b expected 1", obs_wrt); end
    checks++; if (obs_lat != 1) begin errors++; $display("FAIL t1_grant_lat: got %0d expected 1", obs_lat); end
    checks++; if (obs_cmd !== 16'hA5C3) begin errors++; $display("FAIL t1_cmd: got %h expected a5c3", obs_cmd); end
    checks++; if (obs_wrt_one !== 1'b1) begin errors++; $display("FAIL t1_wrt_1cyc: got %b expected 1", obs_wrt_one); end
    checks++; if (obs_cmd_stable !== 1'b1) begin errors++; $display("FAIL t1_cmd_stable: got %b expected 1", obs_cmd_stable); end
    checks++; if (obs_ss_ok !== 1'b1) begin errors++; $display("FAIL t1_ss_decode: got %b expected 1", obs_ss_ok); end
    checks++; if ({obs_cd, obs_ce, obs_ed} !== 3'b100) begin
      errors++; $display("FAIL t1_done: got cd/ce/ed=%b expected 100", {obs_cd, obs_ce, obs_ed}); end
    checks++; if (obs_rd !== 16'h00FF) begin errors++; $display("FAIL t1_rdata: got %h expected 00ff", obs_rd); end
    checks++; if (obs_done_one !== 1'b1) begin errors++; $display("FAIL t1_done_1cyc: got %b expected 1", obs_done_one); end
    exp_last = 0; exp_rdata = 16'h00FF;
    repeat (GAP + 4) tick();
    // Stray mstr_done while idle must neither capture data nor complete anything.
    mstr_data = 16'h1234; mstr_done = 1'b1;
    tick();
    mstr_done = 1'b0;
    tick();
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL stray_rdata: got %h expected %h", rdata, exp_rdata); end
    checks++; if ({cfg_done, eep_done} !== 2'b00) begin errors++; $display("FAIL stray_done: got %b expected 00", {cfg_done, eep_done}); end
  endtask

  task automatic test_illegal();
    int wrts;
    cfg_tgt = 3'd6; cfg_cmd = 16'($urandom); cfg_req = 1'b1;
    run_txn(3'd6, 16'hDEAD, 2);
    cfg_req = 1'b0;
    wrts = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (mstr_wrt) wrts++; end
    checks++; if (obs_wrt !== 1'b0) begin errors++; $display("FAIL t3_no_wrt: got %b expected 0", obs_wrt); end
    checks++; if (wrts != 0) begin errors++; $display("FAIL t3_late_wrt: got %0d expected 0", wrts); end
    checks++; if (obs_lat != 1) begin errors++; $display("FAIL t3_lat: got %0d expected 1", obs_lat); end
    checks++; if ({obs_cd, obs_ce, obs_ed, obs_ee} !== 4'b1100) begin
      errors++; $display("FAIL t3_done_err: got %b expected 1100", {obs_cd, obs_ce, obs_ed, obs_ee}); end
    checks++; if (obs_rd !== exp_rdata) begin errors++; $display("FAIL t3_rdata: got %h expected %h", obs_rd, exp_rdata); end
    checks++; if (obs_done_one !== 1'b1) begin errors++; $display("FAIL t3_done_1cyc: got %b expected 1", obs_done_one); end
    exp_last = 0;
  endtask

  task automatic test_back_to_back();
    int first_done, gap_seen;
    logic [CW-1:0] d0, d1, c0, c1;
    logic [2:0] t0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    exp_last = 1; exp_rdata = '0;
    t0 = 3'($urandom_range(0, 3)); c0 = 16'($urandom); c1 = 16'($urandom);
    d0 = 16'($urandom); d1 = 16'($urandom);
    cfg_tgt = t0; cfg_cmd = c0; cfg_req = 1'b1;
    eep_tgt = 3'd4; eep_cmd = c1; eep_req = 1'b1;
    run_txn(t0, d0, 2);
    cfg_req = 1'b0;
    first_done = obs_done_cyc;
    checks++; if ({obs_cd, obs_ed} !== 2'b10) begin errors++; $display("FAIL t2_first: got cd/ed=%b expected 10", {obs_cd, obs_ed}); end
    checks++; if (obs_cmd !== c0) begin errors++; $display("FAIL t2_cmd0: got %h expected %h", obs_cmd, c0); end
    checks++; if (obs_rd !== d0) begin errors++; $display("FAIL t2_rd0: got %h expected %h", obs_rd, d0); end
    run_txn(3'd4, d1, 3);
    eep_req = 1'b0;
    gap_seen = obs_wrt_cyc - first_done;
    checks++; if ({obs_cd, obs_ed, obs_ee} !== 3'b010) begin errors++; $display("FAIL t2_second: got cd/ed/ee=%b expected 010", {obs_cd, obs_ed, obs_ee}); end
    checks++; if (obs_cmd !== c1) begin errors++; $display("FAIL t2_cmd1: got %h expected %h", obs_cmd, c1); end
    checks++; if (obs_rd !== d1) begin errors++; $display("FAIL t2_rd1: got %h expected %h", obs_rd, d1); end
    checks++; if (obs_ss_ok !== 1'b1) begin errors++; $display("FAIL t2_ss_eep: got %b expected 1", obs_ss_ok); end
    checks++; if (gap_seen < GAP + 1 || gap_seen > GAP + 3) begin
      errors++; $display("FAIL t2_gap: got %0d cycles expected %0d..%0d", gap_seen, GAP + 1, GAP + 3); end
    exp_last = 1; exp_rdata = d1;
    repeat (GAP + 2) tick();
  endtask

  task automatic test_timeout();
    bit seen_wrt, seen_done, mid_low;
    int n;
    eep_tgt = 3'd4; eep_cmd = 16'($urandom); eep_req = 1'b1;
    seen_wrt = 0; seen_done = 0; mid_low = 0; n = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (mstr_wrt) begin seen_wrt = 1; break; end end
    mstr_SS_n = 1'b0;
    for (int i = 1; i <= TMO + 20; i++) begin
      tick();
      if (i == 100) mid_low = (EEP_ss_n === 1'b0);
      if (eep_done) begin n = i; seen_done = 1; break; end
    end
    checks++; if (seen_wrt !== 1'b1) begin errors++; $display("FAIL t4_wrt: got %b expected 1", seen_wrt); end
    checks++; if (mid_low !== 1'b1) begin errors++; $display("FAIL t4_eep_ss_low: got %b expected 1", mid_low); end
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL t4_done: got %b expected 1", seen_done); end
    checks++; if (n < TMO || n > TMO + 3) begin errors++; $display("FAIL t4_tmo_cycles: got %0d expected %0d..%0d", n, TMO, TMO + 3); end
    checks++; if ({eep_err, cfg_done} !== 2'b10) begin errors++; $display("FAIL t4_err: got ee/cd=%b expected 10", {eep_err, cfg_done}); end
    checks++; if (ss_vec() !== 5'h1F) begin errors++; $display("FAIL t4_ss_released: got %b expected 11111", ss_vec()); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL t4_rdata: got %h expected %h", rdata, exp_rdata); end
    mstr_SS_n = 1'b1; eep_req = 1'b0;
    exp_last = 1;
    repeat (GAP + 3) tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    logic ch1_low;
    cfg_tgt = 3'd0; cfg_cmd = 16'($urandom); cfg_req = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (mstr_wrt) break; end
    mstr_SS_n = 1'b0;
    repeat (3) tick();
    ch1_low = ch1_ss_n;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ch1_low !== 1'b0) begin errors++; $display("FAIL t5_ch1_active: got %b expected 0", ch1_low); end
    checks++; if (ss_vec() !== 5'h1F) begin errors++; $display("FAIL t5_ss_async: got %b expected 11111", ss_vec()); end
    checks++; if (mstr_wrt !== 1'b0) begin errors++; $display("FAIL t5_wrt: got %b expected 0", mstr_wrt); end
    checks++; if ({mstr_cmd, rdata} !== 32'h0) begin errors++; $display("FAIL t5_regs: got %h expected 00000000", {mstr_cmd, rdata}); end
    dones = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (cfg_done || eep_done) dones++; end
    rst_n = 1'b1; cfg_req = 1'b0; mstr_SS_n = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (cfg_done || eep_done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL t5_no_done: got %0d expected 0", dones); end
    exp_last = 1; exp_rdata = '0;
  endtask

  task automatic test_round_robin();
    int who;
    logic [CW-1:0] d, wc;
    logic [2:0] wt;
    cfg_tgt = 3'($urandom_range(0, 4)); cfg_cmd = 16'($urandom); cfg_req = 1'b1;
    eep_tgt = 3'($urandom_range(0, 4)); eep_cmd = 16'($urandom); eep_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      who = predict(1'b1, 1'b1);
      wt = (who == 0) ? cfg_tgt : eep_tgt;
      wc = (who == 0) ? cfg_cmd : eep_cmd;
      d = 16'($urandom);
      run_txn(wt, d, 1 + int'($urandom_range(0, 4)));
      checks++; if ({obs_cd, obs_ed} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL t6_order[%0d]: got cd/ed=%b expected %b", t, {obs_cd, obs_ed}, (t % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (obs_cmd !== wc) begin errors++; $display("FAIL t6_cmd[%0d]: got %h expected %h", t, obs_cmd, wc); end
      checks++; if (obs_rd !== d) begin errors++; $display("FAIL t6_rdata[%0d]: got %h expected %h", t, obs_rd, d); end
      checks++; if (obs_ss_ok !== 1'b1) begin errors++; $display("FAIL t6_ss[%0d]: got %b expected 1", t, obs_ss_ok); end
      exp_last = who; exp_rdata = d;
      if (who == 0) begin cfg_tgt = 3'($urandom_range(0, 4)); cfg_cmd = 16'($urandom); end
      else begin eep_tgt = 3'($urandom_range(0, 4)); eep_cmd = 16'($urandom); end
    end
    cfg_req = 1'b0; eep_req = 1'b0;
    repeat (GAP + 3) tick();
  endtask

  task automatic test_random();
    int who;
    logic c, e, legal;
    logic [CW-1:0] d, wc;
    logic [2:0] wt;
    for (int r = 0; r < 12; r++) begin
      c = 1'($urandom); e = 1'($urandom);
      if (!c && !e) c = 1'b1;
      cfg_tgt = 3'($urandom); cfg_cmd = 16'($urandom);
      eep_tgt = 3'($urandom); eep_cmd = 16'($urandom);
      cfg_req = c; eep_req = e;
      who = predict(c, e);
      wt = (who == 0) ? cfg_tgt : eep_tgt;
      wc = (who == 0) ? cfg_cmd : eep_cmd;
      legal = (wt < 3'd5);
      d = 16'($urandom);
      run_txn(wt, d, 1 + int'($urandom_range(0, 3)));
      cfg_req = 1'b0; eep_req = 1'b0;
      checks++; if (obs_wrt !== legal) begin errors++; $display("FAIL rnd_wrt[%0d]: got %b expected %b", r, obs_wrt, legal); end
      checks++; if ({obs_cd, obs_ed} !== ((who == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rnd_owner[%0d]: got cd/ed=%b expected %b", r, {obs_cd, obs_ed}, (who == 0) ? 2'b10 : 2'b01); end
      checks++; if ((obs_ce | obs_ee) !== !legal) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", r, obs_ce | obs_ee, !legal); end
      if (legal) begin
        exp_rdata = d;
        checks++; if (obs_cmd !== wc) begin errors++; $display("FAIL rnd_cmd[%0d]: got %h expected %h", r, obs_cmd, wc); end
        checks++; if (obs_ss_ok !== 1'b1) begin errors++; $display("FAIL rnd_ss[%0d]: got %b expected 1", r, obs_ss_ok); end
      end
      checks++; if (obs_rd !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", r, obs_rd, exp_rdata); end
      exp_last = who;
      repeat (GAP + 2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
